// File: rtl/complex_alu_seq_if.sv
// Operand/result handshake bundle for the sequential complex ALU.
// The master drives operands and out_ready; the slave is the ALU itself.
interface complex_alu_seq_if #(
  parameter int W = 8
) ();
  localparam int OW = 2 * W + 2;

  logic                 in_valid;
  logic                 in_ready;
  logic [2:0]           op;
  logic signed [W-1:0]  r1;
  logic signed [W-1:0]  i1;
  logic signed [W-1:0]  r2;
  logic signed [W-1:0]  i2;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [OW-1:0] re_out;
  logic signed [OW-1:0] im_out;
  logic                 err;

  modport master (
    output in_valid, op, r1, i1, r2, i2, out_ready,
    input  in_ready, out_valid, re_out, im_out, err
  );

  modport slave (
    input  in_valid, op, r1, i1, r2, i2, out_ready,
    output in_ready, out_valid, re_out, im_out, err
  );
endinterface

// File: rtl/complex_alu_seq.sv
// Sequential complex ALU: single-cycle add/sub/mul/conj/magsq, and division through a
// (2W+1)-iteration restoring divider that runs both result components in parallel.
module complex_alu_seq #(
  parameter int W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  complex_alu_seq_if.slave  bus
);
  localparam int OW = 2 * W + 2;
  localparam int NW = 2 * W + 1;
  localparam int CW = $clog2(NW + 1);

  localparam logic [2:0] OpAdd   = 3'b000;
  localparam logic [2:0] OpSub   = 3'b001;
  localparam logic [2:0] OpMul   = 3'b010;
  localparam logic [2:0] OpDiv   = 3'b011;
  localparam logic [2:0] OpConj  = 3'b100;
  localparam logic [2:0] OpMagsq = 3'b101;

  typedef enum logic [1:0] {StIdle, StDiv, StDone} state_e;

  state_e state_q, state_d;

  logic signed [OW-1:0] ar, ai, br, bi;
  logic signed [OW-1:0] num_re, num_im;
  logic [NW-1:0]        den;
  logic                 den_zero;
  logic                 is_div;
  logic [NW-1:0]        mag_re, mag_im;

  logic signed [OW-1:0] res_re, res_im;
  logic                 res_err;

  logic signed [OW-1:0] re_q, im_q;
  logic                 err_q;
  logic [CW-1:0]        cnt_q;
  logic [NW-1:0]        den_q;
  logic [NW-1:0]        rem_q [2];
  logic [NW-1:0]        quo_q [2];
  logic                 neg_q [2];

  logic [NW:0]          trial [2];
  logic                 fit   [2];
  logic [NW-1:0]        rem_d [2];
  logic [NW-1:0]        quo_d [2];
  logic signed [OW-1:0] quo_res [2];
  logic                 div_last;

  // Operands are widened to the result width up front so no intermediate can wrap.
  assign ar = {{(OW - W){bus.r1[W-1]}}, bus.r1};
  assign ai = {{(OW - W){bus.i1[W-1]}}, bus.i1};
  assign br = {{(OW - W){bus.r2[W-1]}}, bus.r2};
  assign bi = {{(OW - W){bus.i2[W-1]}}, bus.i2};

  assign num_re   = ar * br + ai * bi;
  assign num_im   = br * ai - ar * bi;
  assign den      = NW'(br * br + bi * bi);
  assign den_zero = (den == '0);
  assign is_div   = (bus.op == OpDiv);
  assign mag_re   = NW'(num_re[OW-1] ? -num_re : num_re);
  assign mag_im   = NW'(num_im[OW-1] ? -num_im : num_im);
  assign div_last = (cnt_q == CW'(NW - 1));

  // Single-cycle results; a zero-denominator divide lands here as an error.
  always_comb begin
    res_re  = '0;
    res_im  = '0;
    res_err = 1'b0;
    case (bus.op)
      OpAdd: begin
        res_re = ar + br;
        res_im = ai + bi;
      end
      OpSub: begin
        res_re = ar - br;
        res_im = ai - bi;
      end
      OpMul: begin
        res_re = ar * br - ai * bi;
        res_im = ar * bi + br * ai;
      end
      OpDiv:   res_err = den_zero;
      OpConj: begin
        res_re = ar;
        res_im = -ai;
      end
      OpMagsq: res_re = ar * ar + ai * ai;
      default: res_err = 1'b1;
    endcase
  end

  // One restoring step per component: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      trial[k]   = {rem_q[k], quo_q[k][NW-1]};
      fit[k]     = (trial[k] >= {1'b0, den_q});
      rem_d[k]   = fit[k] ? NW'(trial[k] - {1'b0, den_q}) : NW'(trial[k]);
      quo_d[k]   = {quo_q[k][NW-2:0], fit[k]};
      quo_res[k] = neg_q[k] ? -OW'(quo_d[k]) : OW'(quo_d[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          state_d = (is_div && !den_zero) ? StDiv : StDone;
        end
      end
      StDiv: begin
        if (div_last) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == StIdle);
    bus.out_valid = (state_q == StDone);
    bus.re_out    = re_q;
    bus.im_out    = im_q;
    bus.err       = err_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      re_q  <= '0;
      im_q  <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
      den_q <= '0;
      for (int k = 0; k < 2; k++) begin
        rem_q[k] <= '0;
        quo_q[k] <= '0;
        neg_q[k] <= 1'b0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            if (is_div && !den_zero) begin
              cnt_q    <= '0;
              den_q    <= den;
              rem_q[0] <= '0;
              rem_q[1] <= '0;
              quo_q[0] <= mag_re;
              quo_q[1] <= mag_im;
              neg_q[0] <= num_re[OW-1];
              neg_q[1] <= num_im[OW-1];
            end else begin
              re_q  <= res_re;
              im_q  <= res_im;
              err_q <= res_err;
            end
          end
        end
        StDiv: begin
          cnt_q <= cnt_q + 1'b1;
          for (int k = 0; k < 2; k++) begin
            rem_q[k] <= rem_d[k];
            quo_q[k] <= quo_d[k];
          end
          if (div_last) begin
            re_q  <= quo_res[0];
            im_q  <= quo_res[1];
            err_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_complex_alu_seq.sv
// Randomised scoreboard bench for complex_alu_seq: stimulus pushes model results,
// a negedge monitor pops and compares on every accepted output.
module tb_complex_alu_seq;
  localparam int W  = 8;
  localparam int OW = 2 * W + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  complex_alu_seq_if #(.W(W)) bus ();

  complex_alu_seq #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    longint re;
    longint im;
    bit     err;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;
  int n_out    = 0;
  int n_exp    = 0;

  task automatic chk(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference: plain integer complex arithmetic; SV '/' truncates toward zero.
  function automatic exp_t model(input int op, input longint r1, input longint i1,
                                 input longint r2, input longint i2);
    exp_t   e;
    longint d;
    e.re  = 0;
    e.im  = 0;
    e.err = 1'b0;
    case (op)
      0: begin e.re = r1 + r2; e.im = i1 + i2; end
      1: begin e.re = r1 - r2; e.im = i1 - i2; end
      2: begin e.re = r1 * r2 - i1 * i2; e.im = r1 * i2 + r2 * i1; end
      3: begin
        d = r2 * r2 + i2 * i2;
        if (d == 0) e.err = 1'b1;
        else begin
          e.re = (r1 * r2 + i1 * i2) / d;
          e.im = (r2 * i1 - r1 * i2) / d;
        end
      end
      4: begin e.re = r1; e.im = -i1; end
      5: e.re = r1 * r1 + i1 * i1;
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  function automatic int rnd_val();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  task automatic scramble_operands();
    bus.op = 3'($urandom);
    bus.r1 = W'($urandom);
    bus.i1 = W'($urandom);
    bus.r2 = W'($urandom);
    bus.i2 = W'($urandom);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      n_out++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got re=%0d im=%0d err=%0b, want none",
                 bus.re_out, bus.im_out, bus.err);
      end else begin
        e = sb.pop_front();
        chk("result_re", longint'(bus.re_out), e.re);
        chk("result_im", longint'(bus.im_out), e.im);
        chk("result_err", longint'(bus.err), longint'(e.err));
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_idle", longint'(bus.in_ready), 1);
  endtask

  // Issue one operation, check latency/busy, then apply backpressure for 'hold' cycles.
  task automatic issue(input int op, input int r1, input int i1, input int r2, input int i2,
                       input int hold, input bit spurious);
    exp_t e;
    int   lat;
    int   explat;
    wait_idle();
    bus.op       = 3'(op);
    bus.r1       = W'(r1);
    bus.i1       = W'(i1);
    bus.r2       = W'(r2);
    bus.i2       = W'(i2);
    bus.in_valid = 1'b1;
    e = model(op, r1, i1, r2, i2);
    explat = (op == 3 && (r2 * r2 + i2 * i2) != 0) ? 2 * W + 2 : 1;
    sb.push_back(e);
    n_exp++;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    scramble_operands();
    lat = 1;
    while (!bus.out_valid && lat < 60) begin
      chk("in_ready_busy", longint'(bus.in_ready), 0);
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, explat);
    for (int h = 0; h < hold; h++) begin
      if (spurious) begin
        bus.in_valid = 1'b1;
        scramble_operands();
      end
      chk("hold_out_valid", longint'(bus.out_valid), 1);
      chk("hold_in_ready", longint'(bus.in_ready), 0);
      chk("hold_re", longint'(bus.re_out), e.re);
      chk("hold_im", longint'(bus.im_out), e.im);
      chk("hold_err", longint'(bus.err), longint'(e.err));
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("idle_out_valid", longint'(bus.out_valid), 0);
    chk("idle_in_ready", longint'(bus.in_ready), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, want finish before 500000");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    scramble_operands();

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", longint'(bus.in_ready), 1);
    chk("rst_out_valid", longint'(bus.out_valid), 0);
    chk("rst_re", longint'(bus.re_out), 0);
    chk("rst_im", longint'(bus.im_out), 0);
    chk("rst_err", longint'(bus.err), 0);
    rst_n = 1'b1;

    issue(2, 3, 4, 1, -2, 0, 1'b0);
    issue(2, -128, -128, -128, -128, 1, 1'b0);
    issue(3, 11, -2, 1, -2, 0, 1'b0);
    issue(3, -7, 0, 2, 0, 2, 1'b0);
    issue(3, 5, 5, 0, 0, 0, 1'b0);
    issue(7, 1, 2, 3, 4, 0, 1'b0);
    issue(6, 1, 2, 3, 4, 1, 1'b0);
    issue(0, -128, -128, -128, -128, 5, 1'b1);
    issue(1, -128, 127, 127, -128, 0, 1'b0);
    issue(4, 3, -128, 0, 0, 0, 1'b0);
    issue(5, -128, -128, 0, 0, 0, 1'b0);
    issue(3, -128, -128, 1, 0, 0, 1'b0);

    // Reset landing in the middle of a divide.
    wait_idle();
    bus.op       = 3'b011;
    bus.r1       = W'(11);
    bus.i1       = W'(-2);
    bus.r2       = W'(1);
    bus.i2       = W'(-2);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("middiv_busy", longint'(bus.in_ready), 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("middiv_rst_in_ready", longint'(bus.in_ready), 1);
    chk("middiv_rst_out_valid", longint'(bus.out_valid), 0);
    chk("middiv_rst_re", longint'(bus.re_out), 0);
    chk("middiv_rst_im", longint'(bus.im_out), 0);
    chk("middiv_rst_err", longint'(bus.err), 0);
    rst_n = 1'b1;
    issue(0, 1, 1, 2, 2, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      int op, r1, i1, r2, i2;
      op = int'($urandom_range(0, 7));
      r1 = rnd_val();
      i1 = rnd_val();
      r2 = rnd_val();
      i2 = rnd_val();
      if (op == 3 && $urandom_range(0, 5) == 0) begin
        r2 = 0;
        i2 = 0;
      end
      issue(op, r1, i1, r2, i2, int'($urandom_range(0, 3)), 1'($urandom));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 0);
    chk("output_count", n_out, n_exp);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/complex_alu_seq.md
Name: complex_alu_seq

Overview:
- Parametrised, sequential complex-number ALU; successor to the combinational complex add/sub/mul/div/conjugate blocks.
- Operands are signed two's-complement of width W. Operations are selected by an opcode and exchanged over valid/ready handshakes.
- Division runs on an iterative restoring divider instead of a combinational `/`.
- Sits between the operand register file and the result writeback stage of the complex datapath.

Parameters:
- W, 8, operand width per real/imag component (signed, W >= 4)
- OW, 2*W+2, result width per component (signed); derived, do not override

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operand/opcode valid
- in_ready  out  1  block can accept operands
- op  in  3  000 add, 001 sub, 010 mul, 011 div, 100 conj(A), 101 magsq(A), 110/111 illegal
- r1, i1  in  W each  operand A (signed)
- r2, i2  in  W each  operand B (signed)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- re_out, im_out  out  OW each  result (signed)
- err  out  1  qualifies result: div-by-zero or illegal op

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is synchronous and active-low on rst_n; it takes priority over everything, including mid-division.
  - Reset values: state=IDLE, in_ready=1, out_valid=0, re_out=0, im_out=0, err=0, divider count=0.
- States and handshake:
  - IDLE: in_ready=1. On in_valid&in_ready (cycle T), latch op and operands.
    - Non-div op: compute, register result, go to DONE. out_valid=1 at T+1.
    - op=div: go to DIV.
  - DIV: in_ready=0. Run 2W+1 iterations in parallel for both components, then go to DONE. out_valid=1 at T+1+(2W+1), which is T+18 for W=8.
  - DONE: out_valid=1, in_ready=0. Outputs and err stay stable until out_ready=1, then go to IDLE.
  - No same-cycle pass-through: in_valid asserted in DONE is ignored. Peak throughput is one op per 2 cycles.
- Arithmetic (all results sign-extended to OW, never wrap):
  - add: (r1+r2, i1+i2)
  - sub: (r1-r2, i1-i2)
  - mul: (r1*r2 - i1*i2, r1*i2 + r2*i1). Products are 2W-bit signed; the sum is computed at OW.
  - conj: (r1, -i1). -(-2^(W-1)) = +2^(W-1) is representable.
  - magsq: (r1^2 + i1^2, 0)
  - div:
    - Numerators: Nr = r1*r2 + i1*i2 and Ni = r2*i1 - r1*i2, each (2W+1)-bit signed.
    - Denominator: D = r2^2 + i2^2, 2W-bit unsigned.
    - Divide |N| by D using a restoring divider.
    - Quotient truncates toward zero; negate if N<0. Remainder is discarded.
- Errors:
  - div with D=0: no iterations run. Go straight to DONE at T+1 with re_out=im_out=0, err=1.
  - op 110/111: DONE at T+1 with re_out=im_out=0, err=1.
  - All other cases: err=0.
- Operand inputs may change freely after acceptance; the block works only on latched copies.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles -> in_ready=1, out_valid=0, re_out=im_out=0, err=0.
- mul, W=8: A=3+4j, B=1-2j, accepted at T -> out_valid at T+1, re=11, im=-2, err=0. Then A=B=-128-128j -> re=0, im=32768.
- div: A=11-2j, B=1-2j, accepted at T -> in_ready=0 for T+1..T+17, out_valid at T+18, re=3, im=4. Negative case A=-7+0j, B=2+0j -> re=-3 (truncates toward zero), im=0.
- Div-by-zero and illegal op:
  - div with B=0+0j -> out_valid at T+1, re=im=0, err=1.
  - op=111 -> same response.
- add extremes and backpressure:
  - A=B=-128-128j, add -> re=im=-256.
  - Hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0, and a second in_valid is ignored.
  - Raise out_ready -> IDLE next cycle.
- Reset mid-division: assert rst_n=0 at T+8 of a div -> next cycle IDLE with all outputs at reset values. A following add 1+1j + 2+2j -> 3+3j.
